// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad event path.
//   KEY_NONE       : scanner code meaning "no key".
//   KEY_A..KEY_D,
//   KEY_HASH,
//   KEY_STAR       : named key codes.
//   kq_state_t     : debouncer FSM states.
//   cnt_width()    : width of a counter that must reach the largest of
//                    three cycle limits without wrapping.
// ---------------------------------------------------------------------------
package keypad_pkg;

  localparam logic [4:0] KEY_NONE = 5'd31;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_HASH = 4'd14;
  localparam logic [3:0] KEY_STAR = 4'd15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kq_state_t;

  function automatic int cnt_width(input int unsigned a,
                                   input int unsigned b,
                                   input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 32'd1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered head output.
//   clk, rst_n : clock, synchronous active-low reset.
//   push, din  : write request and data; ignored when full unless a pop
//                happens in the same cycle.
//   pop        : remove the head entry; ignored when empty.
//   dout       : registered copy of the head entry (0 after reset).
//   full/empty : occupancy flags.
//   count      : occupancy, 0..DEPTH.
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_next;
  logic [WIDTH-1:0] head_next;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == PW'(DEPTH));
  assign empty   = (count == {PW{1'b0}});
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next head value: bypass din when the slot being written becomes the head.
  always_comb begin
    rd_next = rd_ptr + PW'(do_pop);
    if (do_push && (rd_next == wr_ptr)) begin
      head_next = din;
    end else begin
      head_next = mem[rd_next[AW-1:0]];
    end
  end

  // Storage, pointers and registered head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      dout   <= {WIDTH{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr <= rd_next;
      end
      dout <= head_next;
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// ---------------------------------------------------------------------------
// key_event_queue
// Debounces the keypad scanner output and queues one event per key press.
//   clk, rst_n     : 27 MHz clock, synchronous active-low reset.
//   key            : raw scanner code, 0-15 valid, 31 = none.
//   keypad_pressed : raw press flag.
//   ev_ready       : consumer accepts the head event.
//   ev_valid       : an event is waiting.
//   ev_key         : head event code (registered).
//   ev_count       : FIFO occupancy.
//   overflow       : sticky, an event was dropped; ovf_clr clears it
//                    (a new drop in the same cycle wins).
//   key_held       : a debounced key is down.
// Build option: define KEY_REPEAT_EN for auto-repeat while a key is held.
// ---------------------------------------------------------------------------
module key_event_queue
  import keypad_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 270000,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned REPEAT_DELAY  = 13500000,
  parameter int unsigned REPEAT_PERIOD = 5400000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             key,
  input  logic                   keypad_pressed,
  input  logic                   ev_ready,
  output logic                   ev_valid,
  output logic [3:0]             ev_key,
  output logic [$clog2(DEPTH):0] ev_count,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic                   key_held
);

  localparam int CW = cnt_width(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 32'd1);

  logic [4:0]    key_meta;
  logic [4:0]    key_sync;
  logic          pressed_meta;
  logic          pressed_sync;
  logic [4:0]    samp;

  kq_state_t     state;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;
  logic          push_req;
  logic [3:0]    push_key;

  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 32'd1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 32'd1);
  logic [CW-1:0] rep_cnt;
  logic          rep_phase;   // 0: waiting for first repeat, 1: periodic
`endif

  // Two-flop synchronizer; the scanner runs on a divided clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_meta     <= KEY_NONE;
      key_sync     <= KEY_NONE;
      pressed_meta <= 1'b0;
      pressed_sync <= 1'b0;
    end else begin
      key_meta     <= key;
      key_sync     <= key_meta;
      pressed_meta <= keypad_pressed;
      pressed_sync <= pressed_meta;
    end
  end

  // Collapse flag + code into one sample; codes 16..31 count as no key.
  always_comb begin
    if (pressed_sync && !key_sync[4]) begin
      samp = {1'b0, key_sync[3:0]};
    end else begin
      samp = KEY_NONE;
    end
  end

  // Debounce FSM. push_req is a one-cycle strobe consumed by the FIFO on
  // the following edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cand     <= 4'd0;
      cnt      <= {CW{1'b0}};
      key_held <= 1'b0;
      push_req <= 1'b0;
      push_key <= 4'd0;
`ifdef KEY_REPEAT_EN
      rep_cnt   <= {CW{1'b0}};
      rep_phase <= 1'b0;
`endif
    end else begin
      push_req <= 1'b0;
      case (state)
        IDLE: begin
          if (samp != KEY_NONE) begin
            cand  <= samp[3:0];
            cnt   <= {CW{1'b0}};
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (samp == KEY_NONE) begin
            state <= IDLE;
          end else if (samp[3:0] != cand) begin
            cand <= samp[3:0];
            cnt  <= {CW{1'b0}};
          end else if (cnt == STABLE_LAST) begin
            push_req <= 1'b1;
            push_key <= cand;
            key_held <= 1'b1;
            state    <= HELD;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= {CW{1'b0}};
            rep_phase <= 1'b0;
`endif
          end else begin
            cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        HELD: begin
          // Other keys pressed while held are deliberately ignored.
          if (samp == KEY_NONE) begin
            cnt   <= {CW{1'b0}};
            state <= RELEASE;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= {CW{1'b0}};
            rep_phase <= 1'b0;
          end else if (!rep_phase && (rep_cnt == DELAY_LAST)) begin
            push_req  <= 1'b1;
            push_key  <= cand;
            rep_cnt   <= {CW{1'b0}};
            rep_phase <= 1'b1;
          end else if (rep_phase && (rep_cnt == PERIOD_LAST)) begin
            push_req <= 1'b1;
            push_key <= cand;
            rep_cnt  <= {CW{1'b0}};
          end else begin
            rep_cnt <= rep_cnt + {{(CW-1){1'b0}}, 1'b1};
`endif
          end
        end
        RELEASE: begin
          // A short dropout is a contact bounce: resume HELD, no new event.
          if (samp != KEY_NONE) begin
            state <= HELD;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= {CW{1'b0}};
            rep_phase <= 1'b0;
`endif
          end else if (cnt == STABLE_LAST) begin
            key_held <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ev_valid = !fifo_empty;
  assign pop      = ev_valid && ev_ready;

  // Sticky overflow: a push that finds the FIFO full with no pop is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

  sync_fifo #(
    .WIDTH (4),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (push_key),
    .pop   (pop),
    .dout  (ev_key),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (ev_count)
  );

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Downstream consumer of the 4x4 keypad scanner. Takes its raw `key` code and `keypad_pressed` flag and debounces them.
- Emits exactly one event per physical key press, encoded 0-15.
- Events are buffered in a small FIFO and handed to the game logic over a valid/ready handshake, so no press is lost while the game FSM is busy.

Parameters:
- STABLE_CYCLES, 270000, consecutive clk cycles a sample must hold before a press or release is accepted (10 ms at 27 MHz).
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- REPEAT_DELAY, 13500000, cycles a key must stay held before the first auto-repeat (only with KEY_REPEAT_EN).
- REPEAT_PERIOD, 5400000, cycles between later auto-repeats (only with KEY_REPEAT_EN).

Ports:
- clk  in  1  system clock, 27 MHz.
- rst_n  in  1  synchronous active-low reset.
- key  in  5  raw code from the scanner; 0-15 is a valid key, 31 means none.
- keypad_pressed  in  1  raw press flag from the scanner.
- ev_ready  in  1  consumer accepts the head event.
- ev_valid  out  1  FIFO is not empty.
- ev_key  out  4  head event code.
- ev_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: an event was dropped.
- ovf_clr  in  1  clears overflow.
- key_held  out  1  a debounced key is currently down.

Behaviour:
- Reset: when rst_n is low at a clk edge, the block returns to the state below.
  - ev_valid=0, ev_key=0, ev_count=0, overflow=0, key_held=0.
  - FSM in IDLE, all counters 0, synchronizers cleared to "none".
- Input path:
  - key and keypad_pressed pass through a 2-flop synchronizer, because the scanner drives them from its divided clock.
  - The synchronized sample is `samp` = key[3:0] when pressed=1 and key<=15; otherwise it is NONE.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
- IDLE:
  - When samp != NONE: cand<=samp, cnt<=0, go to DEBOUNCE.
- DEBOUNCE:
  - samp==NONE: go to IDLE.
  - samp is a different valid key: cand<=samp, cnt<=0.
  - samp==cand and cnt==STABLE_CYCLES-1: push cand, key_held<=1, go to HELD.
  - Otherwise: cnt++.
- HELD:
  - samp==NONE: cnt<=0, go to RELEASE.
  - Any other key while held is ignored; there is no rollover.
- RELEASE:
  - samp!=NONE: go back to HELD; the bounce is absorbed and nothing is pushed.
  - cnt==STABLE_CYCLES-1: key_held<=0, go to IDLE.
  - Otherwise: cnt++.
- Latency:
  - Push occurs on the cycle the DEBOUNCE terminal count is reached.
  - ev_valid rises the next cycle when the FIFO was empty.
  - Minimum press-to-ev_valid time is 2+1+STABLE_CYCLES+1 cycles.
- FIFO:
  - Pop happens when ev_valid && ev_ready.
  - ev_key is registered and shows the head entry. ev_key is don't-care while ev_valid=0, but must not be X after reset.
  - Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
- Boundary cases:
  - Push and pop in the same cycle when empty: not possible, because ev_valid=0.
  - Push and pop in the same cycle when full: both happen, count stays DEPTH, no overflow.
  - Push when full without a pop: the event is dropped and overflow<=1.
  - ovf_clr in the same cycle as a new overflow: set wins.
- Counter width: cnt is $clog2(max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) bits and never wraps.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- When defined, auto-repeat is active in HELD:
  - A repeat counter starts on entry to HELD.
  - At REPEAT_DELAY-1 the block pushes cand again.
  - After that it pushes every REPEAT_PERIOD cycles.
  - The counter stops and resets on entry to RELEASE, and resumes from 0 when RELEASE bounces back to HELD.
  - Repeat pushes follow the same overflow rules as normal pushes.
- When not defined: no repeat logic is built and exactly one event is produced per press.

Decomposition:
- Shared package keypad_pkg holds:
  - KEY_NONE=5'd31.
  - key-code constants: KEY_STAR=15, KEY_HASH=14, KEY_A..KEY_D=10..13.
  - the state enum kq_state_t {IDLE, DEBOUNCE, HELD, RELEASE}.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH), with push/pop/full/empty/count. The debouncer FSM stays in the top module.

Test Plan (bench uses STABLE_CYCLES=4, DEPTH=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Clean press: key=5 with pressed=1 held for 10 cycles, then key=31 -> exactly one event with ev_key=5. ev_valid rises 8 cycles after stimulus. key_held falls 7 cycles after release.
- Bounce: key=7 toggling on/off every 2 cycles for 12 cycles, then held steady -> no event during the bounce, then exactly one event of 7.
- Release glitch: hold key 3, release for 2 cycles, re-press for 5 cycles, then release -> exactly one event of 3.
- Overflow: with ev_ready=0, apply presses 1, 2, 3, 4, 6 -> ev_count=4 and overflow=1. Pops then return 1, 2, 3, 4. ovf_clr drives overflow to 0.
- Full with simultaneous push/pop: FIFO full and ev_ready=1 on the push cycle -> count stays 4, overflow stays 0, new key appears last.
- Reset mid-press: rst_n=0 for 1 cycle during HELD -> all outputs at reset values and the FIFO is empty. A continued hold produces a new event only after re-debounce. With KEY_REPEAT_EN, a 40-cycle hold of key 9 yields events at the press, +20, and +28 cycles.
